// File: rtl/match_interval_logger.sv
// rtl/match_interval_logger.sv - gap-between-matches logger with show-ahead FIFO
module match_interval_logger #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       match,
  input  logic                       clear,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [CNT_W-1:0]           rd_data,
  output logic [CNT_W-1:0]           match_count,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] gap;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             push;

  assign full     = (level == FULL_LVL);
  assign rd_valid = (level != '0);
  assign rd_data  = mem[rd_ptr];

  // A pop in the same edge frees a slot, so a full FIFO can still accept the push.
  assign pop  = rd_valid && rd_ready && !clear;
  assign push = match && !clear && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap         <= '0;
      match_count <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      gap         <= '0;
      match_count <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      overflow    <= 1'b0;
    end else begin
      if (match) begin
        gap <= '0;
        if (match_count != CNT_MAX)
          match_count <= match_count + 1'b1;
        if (full && !pop)
          overflow <= 1'b1;
      end else if (gap != CNT_MAX) begin
        gap <= gap + 1'b1;
      end

      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; entries are only observed while rd_valid is high.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= gap;
  end

endmodule

// File: tb/tb_match_interval_logger.sv
// tb/tb_match_interval_logger.sv - self-checking bench for match_interval_logger
module tb_match_interval_logger;

  localparam int CNT_W = 8;
  localparam int DEPTH = 4;
  localparam int MAXV  = 255;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             match = 1'b0;
  logic             clear = 1'b0;
  logic             rd_ready = 1'b0;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic [CNT_W-1:0] match_count;
  logic [2:0]       level;
  logic             overflow;

  int total = 0;
  int bad = 0;

  match_interval_logger #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .match(match), .clear(clear),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .match_count(match_count), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mask;
    int          n;
    int          lvl;
    int          cnt;
    int          ovf;
    int          d[4];
  } vec_t;

  vec_t tbl[3];
  int   expq[$];

  // Behavioural reference: a queue of gap values plus plain counters.
  int m_q[$];
  int m_gap, m_cnt, m_ovf;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; match = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    step(); step();
    reset_n = 1'b1;
  endtask

  task automatic drain(input string name);
    match = 1'b0;
    foreach (expq[i]) begin
      check({name, "_valid"}, int'(rd_valid), 1);
      check({name, "_data"}, int'(rd_data), expq[i]);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
    check({name, "_empty"}, int'(rd_valid), 0);
    expq.delete();
  endtask

  task automatic model_edge(input bit mt, input bit cl, input bit rr);
    if (cl) begin
      m_q.delete(); m_gap = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      if (rr && m_q.size() > 0) void'(m_q.pop_front());
      if (mt) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_gap);
        else m_ovf = 1;
        m_gap = 0;
        m_cnt = (m_cnt < MAXV) ? m_cnt + 1 : MAXV;
      end else begin
        m_gap = (m_gap < MAXV) ? m_gap + 1 : MAXV;
      end
    end
  endtask

  initial begin
    tbl[0] = '{mask: 16'h1028, n: 13, lvl: 3, cnt: 3, ovf: 0, d: '{3, 1, 6, 0}};
    tbl[1] = '{mask: 16'h0074, n: 7,  lvl: 4, cnt: 4, ovf: 0, d: '{2, 1, 0, 0}};
    tbl[2] = '{mask: 16'h02AA, n: 10, lvl: 4, cnt: 5, ovf: 1, d: '{1, 1, 1, 1}};

    do_reset();
    check("reset_valid", int'(rd_valid), 0);
    check("reset_level", int'(level), 0);
    check("reset_count", int'(match_count), 0);
    check("reset_ovf", int'(overflow), 0);

    foreach (tbl[t]) begin
      do_reset();
      for (int e = 0; e < tbl[t].n; e++) begin
        match = tbl[t].mask[e];
        step();
      end
      match = 1'b0;
      check($sformatf("vec%0d_level", t), int'(level), tbl[t].lvl);
      check($sformatf("vec%0d_count", t), int'(match_count), tbl[t].cnt);
      check($sformatf("vec%0d_ovf", t), int'(overflow), tbl[t].ovf);
      for (int i = 0; i < tbl[t].lvl; i++) expq.push_back(tbl[t].d[i]);
      drain($sformatf("vec%0d", t));
    end

    // Full FIFO: simultaneous pop and push at edge 11.
    do_reset();
    for (int e = 0; e < 12; e++) begin
      match = (e == 1 || e == 3 || e == 5 || e == 7 || e == 9 || e == 11);
      rd_ready = (e == 11);
      step();
    end
    match = 1'b0; rd_ready = 1'b0;
    check("fullpp_level", int'(level), 4);
    check("fullpp_ovf", int'(overflow), 1);
    check("fullpp_count", int'(match_count), 6);
    expq = '{1, 1, 1, 1};
    drain("fullpp");

    // Gap and count saturation.
    do_reset();
    repeat (300) step();
    match = 1'b1;
    step();
    match = 1'b0;
    expq = '{255};
    drain("gapsat");
    match = 1'b1;
    repeat (260) step();
    match = 1'b0;
    check("cntsat_count", int'(match_count), 255);

    // Clear together with a match while two entries are queued.
    do_reset();
    match = 1'b1; step(); step();
    check("clr_pre_level", int'(level), 2);
    clear = 1'b1; step();
    clear = 1'b0; match = 1'b0;
    check("clr_level", int'(level), 0);
    check("clr_count", int'(match_count), 0);
    check("clr_ovf", int'(overflow), 0);
    check("clr_valid", int'(rd_valid), 0);
    step(); step(); step();
    match = 1'b1; step(); match = 1'b0;
    expq = '{3};
    drain("clr_next");

    // Asynchronous reset assertion mid-cycle.
    do_reset();
    match = 1'b1; step(); step(); step(); match = 1'b0;
    check("ar_pre_level", int'(level), 3);
    #2 reset_n = 1'b0;
    #1;
    check("ar_valid", int'(rd_valid), 0);
    check("ar_level", int'(level), 0);
    step();
    reset_n = 1'b1; match = 1'b1;
    step();
    match = 1'b0;
    expq = '{0};
    drain("ar_first");

    // Randomized traffic against the queue model.
    do_reset();
    m_q.delete(); m_gap = 0; m_cnt = 0; m_ovf = 0;
    for (int c = 0; c < 3000; c++) begin
      match    = ($urandom_range(99) < ((c / 500) % 2 == 0 ? 45 : 8));
      rd_ready = ($urandom_range(99) < 35);
      clear    = ($urandom_range(199) == 0);
      model_edge(match, clear, rd_ready);
      step();
      check("rnd_valid", int'(rd_valid), (m_q.size() > 0) ? 1 : 0);
      check("rnd_level", int'(level), m_q.size());
      check("rnd_count", int'(match_count), m_cnt);
      check("rnd_ovf", int'(overflow), m_ovf);
      if (m_q.size() > 0) check("rnd_data", int'(rd_data), m_q[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
